// File: rtl/aes_mix_pkg.sv
// Shared definitions for the AES (Inv)MixColumns sequencer and its byte datapath.
//   - state_e       : sequencer FSM states
//   - NUM_COLS      : columns in the AES-128 state
//   - INV_COEF      : InvMixColumns row coefficients {0E,0B,0D,09}, index 0 first
//   - FWD_COEF      : MixColumns row coefficients {02,03,01,01}, index 0 first
//   - xtime         : multiply by x in GF(2^8) mod 0x11B
//   - gf_mul_const  : multiply by an 8-bit constant via an xtime chain
package aes_mix_pkg;

  localparam int NUM_COLS = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_e;

  localparam logic [3:0][7:0] INV_COEF = {8'h09, 8'h0d, 8'h0b, 8'h0e};
  localparam logic [3:0][7:0] FWD_COEF = {8'h01, 8'h01, 8'h03, 8'h02};

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Sum of a*x^i for every set bit i of c; with constant c this folds to a few XORs.
  function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [7:0] c);
    logic [7:0] acc;
    logic [7:0] pw;
    acc = '0;
    pw  = a;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) acc ^= pw;
      pw = xtime(pw);
    end
    return acc;
  endfunction

endpackage

// File: rtl/inv_mix_col_seq_if.sv
// Bus bundle between the round controller / state memory and inv_mix_col_seq.
//   start   : begin a pass (controller -> sequencer)
//   rd_addr : state-memory read address, rd_data : read data (RD_LAT later)
//   wr_en / wr_addr / wr_data : state-memory write port
//   busy    : pass in progress, done : one-cycle completion pulse
//   fwd     : only with MIX_FWD_SUPPORT_EN, selects forward MixColumns
// Modports: slave = sequencer side, master = controller/memory side.
interface inv_mix_col_seq_if;
  logic       start;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;

`ifdef MIX_FWD_SUPPORT_EN
  logic       fwd;

  modport slave (input start, rd_data, fwd,
                 output rd_addr, wr_en, wr_addr, wr_data, busy, done);
  modport master (output start, rd_data, fwd,
                  input rd_addr, wr_en, wr_addr, wr_data, busy, done);
`else
  modport slave (input start, rd_data,
                 output rd_addr, wr_en, wr_addr, wr_data, busy, done);
  modport master (output start, rd_data,
                  input rd_addr, wr_en, wr_addr, wr_data, busy, done);
`endif

endinterface

// File: rtl/mix_col_byte.sv
// Combinational (Inv)MixColumns for one output byte.
//   col_i  : the four column bytes, col_i[0] = row 0
//   row_i  : output row r
//   fwd_i  : 1 = forward coefficients, 0 = inverse coefficients
//   byte_o : c0*col[r] ^ c1*col[r+1] ^ c2*col[r+2] ^ c3*col[r+3] (row indices mod 4)
module mix_col_byte
  import aes_mix_pkg::*;
(
  input  logic [3:0][7:0] col_i,
  input  logic [1:0]      row_i,
  input  logic            fwd_i,
  output logic [7:0]      byte_o
);

  logic [3:0][7:0] coef;

  always_comb begin
    coef   = fwd_i ? FWD_COEF : INV_COEF;
    // 2-bit row arithmetic gives the mod-4 rotation for free
    byte_o = gf_mul_const(col_i[row_i],         coef[0])
           ^ gf_mul_const(col_i[row_i + 2'd1],  coef[1])
           ^ gf_mul_const(col_i[row_i + 2'd2],  coef[2])
           ^ gf_mul_const(col_i[row_i + 2'd3],  coef[3]);
  end

endmodule

// File: rtl/inv_mix_col_seq.sv
// InvMixColumns sequencer: reads the 16-byte state one column at a time,
// buffers it, and writes the four transformed bytes back in place.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : inv_mix_col_seq_if.slave (start, rd_addr/rd_data, wr_*, busy, done)
// Parameters: RD_LAT (1 or 2) memory read latency, START_COL first column.
// Optional macro MIX_FWD_SUPPORT_EN adds bus.fwd (latched at start) to select
// forward MixColumns coefficients.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_LOAD  | issue 4 reads of the current column (n = 0..3)
// ST_DRAIN | RD_LAT cycles for outstanding read data to land in the buffer
// ST_WRITE | 4 registered writes of the transformed column (r = 0..3)
// ST_DONE  | one-cycle done pulse, then back to idle
module inv_mix_col_seq
  import aes_mix_pkg::*;
#(
  parameter int RD_LAT    = 1,
  parameter int START_COL = 0
) (
  input  logic               clk,
  input  logic               rst,
  inv_mix_col_seq_if.slave   bus
);

  state_e                 state_q;
  logic [1:0]             col_q;
  logic [1:0]             n_q;
  logic [1:0]             r_q;
  logic [1:0]             cols_left_q;
  logic [1:0]             dcnt_q;
  logic [3:0][7:0]        col_buf_q;
  logic [3:0][7:0]        col_buf_d;
  logic [RD_LAT-1:0]      vld_q;
  logic [RD_LAT-1:0][1:0] idx_q;
  logic [3:0]             rd_addr_q;
  logic                   wr_en_q;
  logic [3:0]             wr_addr_q;
  logic [7:0]             wr_data_q;
  logic                   busy_q;
  logic                   done_q;
  logic [1:0]             mix_row;
  logic [7:0]             mix_byte;
  logic                   fwd_sel;

`ifdef MIX_FWD_SUPPORT_EN
  logic                   fwd_q;
  assign fwd_sel = fwd_q;
`else
  assign fwd_sel = 1'b0;
`endif

  // The last byte of a column lands on the same edge that registers the
  // first write, so the datapath sees the buffer with that capture applied.
  always_comb begin
    col_buf_d = col_buf_q;
    if (vld_q[RD_LAT-1]) col_buf_d[idx_q[RD_LAT-1]] = bus.rd_data;
  end

  // Next row to be registered: row 0 when leaving DRAIN, r+1 inside WRITE.
  always_comb begin
    mix_row = (state_q == ST_WRITE) ? r_q + 2'd1 : 2'd0;
  end

  mix_col_byte u_mix (
    .col_i  (col_buf_d),
    .row_i  (mix_row),
    .fwd_i  (fwd_sel),
    .byte_o (mix_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      n_q         <= '0;
      r_q         <= '0;
      cols_left_q <= '0;
      dcnt_q      <= '0;
      col_buf_q   <= '0;
      vld_q       <= '0;
      idx_q       <= '0;
      rd_addr_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MIX_FWD_SUPPORT_EN
      fwd_q       <= 1'b0;
`endif
    end else begin
      // read-valid delay line: a read issued in LOAD is captured RD_LAT cycles later
      vld_q[0] <= (state_q == ST_LOAD);
      idx_q[0] <= n_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
      col_buf_q <= col_buf_d;
      done_q    <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q     <= ST_LOAD;
            col_q       <= START_COL[1:0];
            n_q         <= 2'd0;
            cols_left_q <= 2'(NUM_COLS - 1);
            rd_addr_q   <= {START_COL[1:0], 2'd0};
            busy_q      <= 1'b1;
`ifdef MIX_FWD_SUPPORT_EN
            fwd_q       <= bus.fwd;
`endif
          end
        end
        ST_LOAD: begin
          if (n_q == 2'd3) begin
            state_q <= ST_DRAIN;
            dcnt_q  <= 2'(RD_LAT - 1);
          end else begin
            n_q       <= n_q + 2'd1;
            rd_addr_q <= {col_q, n_q + 2'd1};
          end
        end
        ST_DRAIN: begin
          if (dcnt_q == 2'd0) begin
            state_q   <= ST_WRITE;
            r_q       <= 2'd0;
            wr_en_q   <= 1'b1;
            wr_addr_q <= {col_q, 2'd0};
            wr_data_q <= mix_byte;
          end else begin
            dcnt_q <= dcnt_q - 2'd1;
          end
        end
        ST_WRITE: begin
          if (r_q == 2'd3) begin
            wr_en_q <= 1'b0;
            if (cols_left_q == 2'd0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= ST_LOAD;
              cols_left_q <= cols_left_q - 2'd1;
              col_q       <= col_q + 2'd1;
              n_q         <= 2'd0;
              rd_addr_q   <= {col_q + 2'd1, 2'd0};
            end
          end else begin
            r_q       <= r_q + 2'd1;
            wr_addr_q <= {col_q, r_q + 2'd1};
            wr_data_q <= mix_byte;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_inv_mix_col_seq.sv
// Bench for inv_mix_col_seq: two instances (RD_LAT=1/START_COL=0 and
// RD_LAT=2/START_COL=2) each with its own state memory. Expected writes
// (cycle, address, data) are queued when a pass is started and consumed by
// a monitor on the falling edge.
module tb_inv_mix_col_seq;

  localparam int LAT0 = 1, SC0 = 0;
  localparam int LAT1 = 2, SC1 = 2;

  localparam logic [7:0] INV_M [4][4] = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09},
                                          '{8'h09, 8'h0e, 8'h0b, 8'h0d},
                                          '{8'h0d, 8'h09, 8'h0e, 8'h0b},
                                          '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
  localparam logic [7:0] FWD_M [4][4] = '{'{8'h02, 8'h03, 8'h01, 8'h01},
                                          '{8'h01, 8'h02, 8'h03, 8'h01},
                                          '{8'h01, 8'h01, 8'h02, 8'h03},
                                          '{8'h03, 8'h01, 8'h01, 8'h02}};
  localparam logic [7:0] VEC_A [16] = '{8'h8e, 8'h4d, 8'ha1, 8'hbc, 8'h9f, 8'hdc, 8'h58, 8'h9d,
                                        8'h01, 8'h01, 8'h01, 8'h01, 8'hc6, 8'hc6, 8'hc6, 8'hc6};
  localparam logic [7:0] EXP_A [16] = '{8'hdb, 8'h13, 8'h53, 8'h45, 8'hf2, 8'h0a, 8'h22, 8'h5c,
                                        8'h01, 8'h01, 8'h01, 8'h01, 8'hc6, 8'hc6, 8'hc6, 8'hc6};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inv_mix_col_seq_if bus0();
  inv_mix_col_seq_if bus1();

  inv_mix_col_seq #(.RD_LAT(LAT0), .START_COL(SC0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  inv_mix_col_seq #(.RD_LAT(LAT1), .START_COL(SC1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [7:0] mem [2][16];
  logic [7:0] rd1 [2];
  logic [7:0] rd2 [2];
  logic       start_v [2];
  logic       fwd_v;
  logic       wr_en_s [2];
  logic [3:0] wr_addr_s [2];
  logic [3:0] rd_addr_s [2];
  logic [7:0] wr_data_s [2];
  logic       busy_s [2];
  logic       done_s [2];

  assign bus0.start   = start_v[0];
  assign bus1.start   = start_v[1];
  assign bus0.rd_data = rd1[0];
  assign bus1.rd_data = rd2[1];
`ifdef MIX_FWD_SUPPORT_EN
  assign bus0.fwd = fwd_v;
  assign bus1.fwd = fwd_v;
`endif
  assign wr_en_s[0]   = bus0.wr_en;   assign wr_en_s[1]   = bus1.wr_en;
  assign wr_addr_s[0] = bus0.wr_addr; assign wr_addr_s[1] = bus1.wr_addr;
  assign rd_addr_s[0] = bus0.rd_addr; assign rd_addr_s[1] = bus1.rd_addr;
  assign wr_data_s[0] = bus0.wr_data; assign wr_data_s[1] = bus1.wr_data;
  assign busy_s[0]    = bus0.busy;    assign busy_s[1]    = bus1.busy;
  assign done_s[0]    = bus0.done;    assign done_s[1]    = bus1.done;

  // state memories with registered read (one or two stages)
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      rd1[k] <= mem[k][rd_addr_s[k]];
      rd2[k] <= rd1[k];
      if (wr_en_s[k]) mem[k][wr_addr_s[k]] <= wr_data_s[k];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         k;
    int         cyc;
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] exp_mem [2][16];
  bit         pass_on [2];
  int         st_cyc [2];
  int         done_cyc [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // GF(2^8) product by shift-and-add with reduction by 0x11B
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] aa;
    logic [7:0] p;
    aa = {1'b0, a};
    p  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa[7:0];
      aa = aa << 1;
      if (aa[8]) aa ^= 9'h11b;
    end
    return p;
  endfunction

  function automatic int first_idx(input int k);
    for (int i = 0; i < exp_q.size(); i++)
      if (exp_q[i].k == k) return i;
    return -1;
  endfunction

  task automatic push_pass(input int s, input bit fwd);
    for (int k = 0; k < 2; k++) begin
      int lat;
      int sc;
      int c;
      wr_t e;
      lat = (k == 0) ? LAT0 : LAT1;
      sc  = (k == 0) ? SC0 : SC1;
      for (int j = 0; j < 4; j++) begin
        c = (sc + j) % 4;
        for (int r = 0; r < 4; r++) begin
          e.k    = k;
          e.cyc  = s + 1 + j * (8 + lat) + 4 + lat + r;
          e.addr = 4'(4 * c + r);
          e.data = 8'h00;
          for (int i = 0; i < 4; i++)
            e.data ^= gmul(fwd ? FWD_M[r][i] : INV_M[r][i], exp_mem[k][4 * c + i]);
          exp_q.push_back(e);
        end
      end
      pass_on[k]  = 1'b1;
      st_cyc[k]   = s;
      done_cyc[k] = s + 1 + 4 * (8 + lat);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (cyc >= 2) begin
      for (int k = 0; k < 2; k++) begin
        int   idx;
        wr_t  e;
        logic exp_busy;
        logic exp_done;
        idx = first_idx(k);
        while (idx >= 0 && exp_q[idx].cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_write dut%0d: required addr %0d data %02h in cycle %0d, wr_en stayed low",
                   k, exp_q[idx].addr, exp_q[idx].data, exp_q[idx].cyc);
          exp_q.delete(idx);
          idx = first_idx(k);
        end
        if (wr_en_s[k]) begin
          checks++;
          if (idx < 0) begin
            errors++;
            $display("FAIL unexpected_write dut%0d: addr %0d data %02h in cycle %0d, required no write",
                     k, wr_addr_s[k], wr_data_s[k], cyc);
          end else begin
            e = exp_q[idx];
            exp_q.delete(idx);
            if (e.cyc != cyc || e.addr !== wr_addr_s[k] || e.data !== wr_data_s[k]) begin
              errors++;
              $display("FAIL write dut%0d: got cyc %0d addr %0d data %02h, required cyc %0d addr %0d data %02h",
                       k, cyc, wr_addr_s[k], wr_data_s[k], e.cyc, e.addr, e.data);
            end
            exp_mem[k][e.addr] = e.data;
          end
        end
        exp_busy = pass_on[k] && cyc > st_cyc[k] && cyc <= done_cyc[k];
        chk($sformatf("busy dut%0d cyc %0d", k, cyc), 32'(busy_s[k]), 32'(exp_busy));
        exp_done = pass_on[k] && cyc == done_cyc[k];
        if (done_s[k] || exp_done)
          chk($sformatf("done dut%0d cyc %0d", k, cyc), 32'(done_s[k]), 32'(exp_done));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_mem(input logic [7:0] v [16]);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) begin
        mem[k][i]     <= v[i];
        exp_mem[k][i]  = v[i];
      end
    tick();
  endtask

  task automatic load_random();
    logic [7:0] v [16];
    for (int i = 0; i < 16; i++) v[i] = 8'($urandom);
    load_mem(v);
  endtask

  task automatic compare_mem(input string tag);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++)
        chk($sformatf("%s mem dut%0d[%0d]", tag, k, i), 32'(mem[k][i]), 32'(exp_mem[k][i]));
  endtask

  task automatic compare_const(input string tag, input logic [7:0] v [16], input int n);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < n; i++)
        chk($sformatf("%s dut%0d[%0d]", tag, k, i), 32'(mem[k][i]), 32'(v[i]));
  endtask

  task automatic run_pass(input bit ign, input bit fwd);
    int s;
    int end_c;
    s          = cyc;
    fwd_v      = fwd;
    start_v[0] = 1'b1;
    start_v[1] = 1'b1;
    push_pass(s, fwd);
    end_c = ((done_cyc[0] > done_cyc[1]) ? done_cyc[0] : done_cyc[1]) + 3;
    while (cyc < end_c) begin
      tick();
      for (int k = 0; k < 2; k++)
        start_v[k] = ign && (cyc == s + 10 || cyc == done_cyc[k]);
    end
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    pass_on[0] = 1'b0;
    pass_on[1] = 1'b0;
    chk("pending_writes_after_pass", 32'(exp_q.size()), 32'd0);
    compare_mem("pass");
  endtask

  initial begin
    logic [7:0] va [16];
    logic [7:0] ea [16];
    int s;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    fwd_v      = 1'b0;
    pass_on[0] = 1'b0;
    pass_on[1] = 1'b0;
    rst        = 1'b1;
    va = VEC_A;
    ea = EXP_A;
    load_mem(va);
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset rd_addr dut%0d", k), 32'(rd_addr_s[k]), 32'd0);
      chk($sformatf("reset wr_en dut%0d", k),   32'(wr_en_s[k]),   32'd0);
      chk($sformatf("reset wr_addr dut%0d", k), 32'(wr_addr_s[k]), 32'd0);
      chk($sformatf("reset wr_data dut%0d", k), 32'(wr_data_s[k]), 32'd0);
      chk($sformatf("reset busy dut%0d", k),    32'(busy_s[k]),    32'd0);
      chk($sformatf("reset done dut%0d", k),    32'(done_s[k]),    32'd0);
    end
    rst = 1'b0;
    tick();

    // known vector, with starts pulsed mid-pass and in the done cycle
    run_pass(1'b1, 1'b0);
    compare_const("vecA", ea, 16);

    for (int t = 0; t < 3; t++) begin
      load_random();
      run_pass(1'b0, 1'b0);
    end

    // reset in cycle 15 of a pass
    load_random();
    s          = cyc;
    fwd_v      = 1'b0;
    start_v[0] = 1'b1;
    start_v[1] = 1'b1;
    push_pass(s, 1'b0);
    tick();
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    while (cyc < s + 15) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    pass_on[0] = 1'b0;
    pass_on[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("abort rd_addr dut%0d", k), 32'(rd_addr_s[k]), 32'd0);
      chk($sformatf("abort wr_addr dut%0d", k), 32'(wr_addr_s[k]), 32'd0);
      chk($sformatf("abort wr_data dut%0d", k), 32'(wr_data_s[k]), 32'd0);
      chk($sformatf("abort done dut%0d", k),    32'(done_s[k]),    32'd0);
    end
    for (int i = 0; i < 6; i++) tick();
    compare_mem("abort");
    run_pass(1'b0, 1'b0);

`ifdef MIX_FWD_SUPPORT_EN
    load_random();
    va = '{8'hdb, 8'h13, 8'h53, 8'h45, 8'hd4, 8'hd4, 8'hd4, 8'hd5,
           8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 8; i < 16; i++) va[i] = 8'($urandom);
    load_mem(va);
    run_pass(1'b0, 1'b1);
    ea = '{8'h8e, 8'h4d, 8'ha1, 8'hbc, 8'hd5, 8'hd5, 8'hd7, 8'hd6,
           8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    compare_const("fwd", ea, 8);
    load_random();
    run_pass(1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
